corr_window_loader: RTL
=======================

// Module: corr_window_loader
// PURPOSE
//  Upstream feeder for the 10-tap correlator. Accepts a serial stream of DW-bit
//  samples over a valid/ready handshake, first loading a coefficient set, then
//  building a sliding window of the last TAPS samples.
//  Presents the window (x) and coefficients (h) as parallel buses that map
//  directly onto the correlator's x_0..x_9 / h_0..h_9 inputs.
//  Pulses win_valid whenever a new full window is available.
// PARAMETERS
//  TAPS  10  number of window taps / coefficients
//  DW    4   sample and coefficient width in bits
// PORTS
//  clock       in   1        system clock, all state on rising edge
//  reset       in   1        asynchronous, active-low reset
//  coef_load   in   1        1-cycle request: start loading a new coefficient set
//  hold        in   1        downstream freeze; blocks acceptance while high
//  in_data     in   DW       sample or coefficient beat
//  in_valid    in   1        in_data valid
//  in_ready    out  1        beat accepted when in_valid && in_ready at posedge
//  x_bus       out  TAPS*DW  window; x_k = x_bus[k*DW +: DW], x_0 = newest sample
//  h_bus       out  TAPS*DW  coefficients; h_k = h_bus[k*DW +: DW], h_0 = first loaded
//  coef_ready  out  1        level: a complete coefficient set is held
//  fill_cnt    out  4        samples in window, saturates at TAPS ($clog2(TAPS+1) bits)
//  win_valid   out  1        1-cycle pulse: new full window on x_bus
// BEHAVIOUR
//  - reset low: state IDLE; x_bus, h_bus, fill_cnt, coef_ready, win_valid = 0.
//    Takes effect immediately, including mid-load or mid-stream.
//  - FSM states IDLE, COEF, FILL, RUN. coef_idx counts 0..TAPS-1.
//  - in_ready = (state != IDLE) && !hold && !coef_load  (combinational).
//  - coef_load in any state has priority:
//    - next state COEF; coef_idx, fill_cnt, coef_ready cleared; x_bus cleared.
//    - Any beat presented in that cycle is NOT accepted.
//  - IDLE: all beats ignored; leave only on coef_load.
//  - COEF: each accepted beat writes h_{coef_idx} and increments coef_idx.
//    - On the TAPS-th beat: next state FILL, coef_ready=1 the following cycle.
//    - h_bus is stable outside COEF.
//  - FILL/RUN: each accepted beat shifts x_k <= x_{k-1} (k=TAPS-1..1),
//    x_0 <= in_data; fill_cnt increments, saturating at TAPS.
//  - FILL -> RUN on the beat that makes fill_cnt == TAPS.
//  - win_valid (registered) = 1 in the cycle after any accepted beat that leaves
//    fill_cnt == TAPS in FILL/RUN; otherwise 0. Latency 1 cycle, one pulse per beat.
//  - hold high: no shift, no counter change, no win_valid; all outputs held.
//  - No wrap: fill_cnt never exceeds TAPS; coef_idx never exceeds TAPS-1.
//  - Width rule: downstream sum of TAPS products of DW x DW is at most
//    10*15*15 = 2250, which fits the correlator's 12-bit output; no truncation here.
// TESTING
//  1. Reset low with in_valid=1, random data -> all outputs 0, in_ready=0.
//     After release, still in_ready=0 (IDLE).
//  2. coef_load pulse, then beats 1..10 -> h_k = k+1.
//     coef_ready rises the cycle after beat 10; win_valid stays 0.
//  3. Samples 1..10 -> fill_cnt 1..10; single win_valid pulse the cycle after
//     sample 10; x_0=10, x_9=1. Correlator output = 220.
//  4. Sample 11 -> x_0=11, x_9=2, win_valid pulse.
//     hold=1 for 3 cycles with in_valid=1 -> in_ready=0, x_bus unchanged, no pulses.
//  5. coef_load in the same cycle as in_valid=1 in RUN -> beat dropped;
//     next cycle fill_cnt=0, coef_ready=0, x_bus=0, state COEF.
//  6. reset low after 4 coefficient beats -> immediate clear to all-zero.
//     After release: IDLE, in_ready=0 until coef_load.

Source files
------------

// File: rtl/corr_window_loader.sv
// Serial feeder for the 10-tap correlator: loads a coefficient set, then keeps a
// sliding window of the newest TAPS samples and flags each new full window.
module corr_window_loader #(
  parameter int TAPS = 10,
  parameter int DW   = 4,
  localparam int CW  = $clog2(TAPS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               coef_load,
  input  logic               hold,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [TAPS*DW-1:0] x_bus,
  output logic [TAPS*DW-1:0] h_bus,
  output logic               coef_ready,
  output logic [CW-1:0]      fill_cnt,
  output logic               win_valid
);

  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {IDLE, COEF, FILL, RUN} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       coef_idx_q, coef_idx_d;
  logic [CW-1:0]       fill_q, fill_d;
  logic [TAPS*DW-1:0]  x_q, x_d;
  logic [TAPS*DW-1:0]  h_q, h_d;
  logic                coef_ready_q, coef_ready_d;
  logic                win_valid_q, win_valid_d;
  logic                accept;

  assign in_ready = (state_q != IDLE) && !hold && !coef_load;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      coef_idx_q   <= '0;
      fill_q       <= '0;
      x_q          <= '0;
      h_q          <= '0;
      coef_ready_q <= 1'b0;
      win_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      coef_idx_q   <= coef_idx_d;
      fill_q       <= fill_d;
      x_q          <= x_d;
      h_q          <= h_d;
      coef_ready_q <= coef_ready_d;
      win_valid_q  <= win_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    coef_idx_d   = coef_idx_q;
    fill_d       = fill_q;
    x_d          = x_q;
    h_d          = h_q;
    coef_ready_d = coef_ready_q;
    win_valid_d  = 1'b0;

    // A load request wins over any beat presented in the same cycle.
    if (coef_load) begin
      state_d      = COEF;
      coef_idx_d   = '0;
      fill_d       = '0;
      coef_ready_d = 1'b0;
      x_d          = '0;
    end else if (accept) begin
      case (state_q)
        COEF: begin
          for (int k = 0; k < TAPS; k++) begin
            if (coef_idx_q == IW'(k)) h_d[k*DW +: DW] = in_data;
          end
          if (coef_idx_q == IW'(TAPS - 1)) begin
            state_d      = FILL;
            coef_ready_d = 1'b1;
            coef_idx_d   = '0;
          end else begin
            coef_idx_d = coef_idx_q + IW'(1);
          end
        end
        FILL, RUN: begin
          // x_0 takes the newest sample; the oldest falls off the top.
          x_d = {x_q[TAPS*DW-DW-1:0], in_data};
          if (fill_q != CW'(TAPS)) fill_d = fill_q + CW'(1);
          if (fill_d == CW'(TAPS)) begin
            win_valid_d = 1'b1;
            state_d     = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign x_bus      = x_q;
  assign h_bus      = h_q;
  assign coef_ready = coef_ready_q;
  assign fill_cnt   = fill_q;
  assign win_valid  = win_valid_q;

endmodule
